fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the address of the first fetch after reset.
REQ-002 Parameter BUF_DEPTH, default 2, the number of fetch buffer entries; only 2 is supported.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 im_req_valid  output  1  fetch request to instruction memory valid.
REQ-006 im_req_ready  input  1  instruction memory accepts the request.
REQ-007 im_req_addr  output  32  fetch address, word-aligned.
REQ-008 im_rsp_valid  input  1  instruction word returned, in request order.
REQ-009 im_rsp_data  input  32  returned instruction word.
REQ-010 id_valid  output  1  the instruction presented to decode is valid.
REQ-011 id_ready  input  1  decode consumes the presented instruction.
REQ-012 id_pc  output  32  PC of the presented instruction.
REQ-013 id_inst  output  32  presented instruction; id_inst[6:0] drives the decode opcode input.
REQ-014 redirect_valid  input  1  a branch, JAL or JALR has resolved taken.
REQ-015 redirect_pc  input  32  target PC for the redirect.

Function
REQ-016 A request handshake completes when im_req_valid and im_req_ready are both 1; fetch_pc then advances by 4, wrapping modulo 2^32.
REQ-017 im_req_addr shall equal fetch_pc, and shall hold stable while im_req_valid=1 and im_req_ready=0.
REQ-018 im_req_valid shall be 1 only when inflight + buffer occupancy < BUF_DEPTH and redirect_valid=0; inflight is a 2-bit count of accepted requests not yet answered.
REQ-019 Each non-discarded response is written to a 2-entry FIFO as {pc, inst}; pc is recorded per request in an in-order 2-entry PC queue.
REQ-020 The decode handshake completes when id_valid and id_ready are both 1; the head entry is then popped.
REQ-021 id_valid=1 exactly when the FIFO is non-empty; id_pc and id_inst show the head entry and hold while id_ready=0.
REQ-022 A FIFO push and pop in the same cycle shall leave occupancy unchanged.
REQ-023 The FIFO shall never overflow, guaranteed by the credit rule in REQ-018.
REQ-024 Redirect cycle: flush the FIFO, fetch_pc <= {redirect_pc[31:2],2'b00}, drop_cnt <= inflight after counting any request accepted that cycle, and im_req_valid=0.
REQ-025 While drop_cnt > 0, each response decrements drop_cnt and is discarded; a response arriving in the redirect cycle itself is also discarded.
REQ-026 A redirect in the same cycle as a decode handshake: the redirect wins and the FIFO ends empty.
REQ-027 Back-to-back redirects: the last redirect defines fetch_pc, and drop_cnt accumulates all outstanding requests.
REQ-028 With im_req_ready=1, a response one cycle after each request, and id_ready=1, throughput shall be one instruction per cycle.

Reset
REQ-029 While rst_n=0: fetch_pc=RESET_PC, inflight=0, drop_cnt=0, FIFO empty, im_req_valid=0, id_valid=0, id_pc=0, id_inst=0.
REQ-030 im_req_valid shall assert with addr RESET_PC in the first clk cycle after rst_n deasserts.
REQ-031 Reset asserted mid-operation shall abandon all outstanding requests; responses arriving after reset exit while inflight=0 are ignored.

Configuration
REQ-032 Macro FETCH_BYPASS_EN selects the response-to-decode path.
- Defined: when the FIFO is empty and a non-discarded response arrives, id_valid=1 in the same cycle with the response data; if id_ready=1 that cycle, nothing is pushed.
- Undefined: every response is pushed first, so id_valid rises no earlier than the cycle after im_rsp_valid.

Verification
REQ-033 Reset release with RESET_PC=0, im_req_ready=1, 1-cycle responses, id_ready=1 -> im_req_addr 0,4,8,... one per cycle; id_pc sequence 0,4,8 with matching id_inst.
REQ-034 id_ready held 0 for 5 cycles -> im_req_valid drops once FIFO plus inflight reaches 2; id_pc/id_inst stable; no instruction lost or duplicated after id_ready=1.
REQ-035 Redirect to 32'h0000_0103 with 2 requests inflight -> next im_req_addr = 32'h0000_0100; both old responses discarded; first id_pc after the redirect = 32'h0000_0100.
REQ-036 Redirect in the same cycle as im_rsp_valid and an id handshake -> FIFO empty and the response dropped; the next id_valid carries the target PC.
REQ-037 fetch_pc = 32'hFFFF_FFFC, request accepted -> next im_req_addr = 32'h0000_0000.
REQ-038 With FETCH_BYPASS_EN defined, empty FIFO and a response with data 32'h0000_0013 -> id_valid=1 and id_inst=32'h0000_0013 in the same cycle; with the macro undefined, one cycle later.

Source files
------------

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Purpose : groups the instruction-memory request/response channel, the
//           decode handshake and the redirect inputs used by fetch_unit.
// Signals :
//   im_req_valid / im_req_ready / im_req_addr  fetch request channel
//   im_rsp_valid / im_rsp_data                 in-order response channel
//   id_valid / id_ready / id_pc / id_inst      decode handshake
//   redirect_valid / redirect_pc               taken branch / jump target
// Modports:
//   master  the fetch unit side
//   slave   the environment side (memory, decode, branch resolution)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
   logic        im_req_valid;
   logic        im_req_ready;
   logic [31:0] im_req_addr;
   logic        im_rsp_valid;
   logic [31:0] im_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output im_req_valid,
      output im_req_addr,
      input  im_req_ready,
      input  im_rsp_valid,
      input  im_rsp_data,
      output id_valid,
      output id_pc,
      output id_inst,
      input  id_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  im_req_valid,
      input  im_req_addr,
      output im_req_ready,
      output im_rsp_valid,
      output im_rsp_data,
      input  id_valid,
      input  id_pc,
      input  id_inst,
      output id_ready,
      output redirect_valid,
      output redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Purpose : instruction fetch stage. Issues word-aligned fetch requests,
//           tracks the PC of every outstanding request, buffers returned
//           instructions in a 2-entry FIFO and presents them to decode.
//           Redirects flush the buffer and discard responses of requests
//           issued before the redirect.
// Ports   :
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    fetch_unit_if.master  (memory request/response, decode, redirect)
// Parameters:
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  fetch buffer entries (only 2 is supported)
// Configuration macro:
//   FETCH_BYPASS_EN  when defined, a response arriving while the buffer is
//                    empty is presented to decode in the same cycle.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   localparam logic [2:0] LP_DEPTH = 3'(BUF_DEPTH);

   // fetch address and request bookkeeping
   logic [31:0] r_fetch_pc;
   logic [1:0]  r_inflight;
   logic [1:0]  r_drop_cnt;

   // in-order PC queue, one entry per outstanding request
   logic [31:0] r_pcq [2];
   logic        r_pcq_wr;
   logic        r_pcq_rd;

   // fetch buffer holding {pc, inst}
   logic [31:0] r_buf_pc   [2];
   logic [31:0] r_buf_inst [2];
   logic        r_buf_wr;
   logic        r_buf_rd;
   logic [1:0]  r_buf_cnt;

   logic        w_req_valid;
   logic        w_req_fire;
   logic        w_rsp_fire;
   logic        w_rsp_drop;
   logic        w_rsp_keep;
   logic [31:0] w_rsp_pc;
   logic        w_buf_empty;
   logic        w_bypass;
   logic        w_id_valid;
   logic        w_id_fire;
   logic        w_push;
   logic        w_pop;
   logic [2:0]  w_used;
   logic [1:0]  w_inflight_nxt;
   logic [1:0]  w_unused_pc_lsbs;

   assign w_unused_pc_lsbs = bus.redirect_pc[1:0];

   // A response only counts while something is outstanding; strays arriving
   // after a reset that abandoned requests are ignored.
   assign w_rsp_fire  = bus.im_rsp_valid & (r_inflight != 2'd0);
   assign w_rsp_pc    = r_pcq[r_pcq_rd];
   assign w_rsp_drop  = w_rsp_fire & (bus.redirect_valid | (r_drop_cnt != 2'd0));
   assign w_rsp_keep  = w_rsp_fire & ~w_rsp_drop;
   assign w_buf_empty = (r_buf_cnt == 2'd0);

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_buf_empty & w_rsp_keep;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_id_valid = ~w_buf_empty | w_bypass;
   assign w_id_fire  = w_id_valid & bus.id_ready;
   assign w_pop      = w_id_fire & ~w_bypass;
   assign w_push     = w_rsp_keep & ~(w_bypass & bus.id_ready);

   // Credit check counts slots released this cycle (decode consumption or a
   // discarded response) so a full pipeline sustains one fetch per cycle
   // without ever exceeding the buffer depth.
   assign w_used = 3'(r_inflight) + 3'(r_buf_cnt) - 3'(w_id_fire) - 3'(w_rsp_drop);

   assign w_req_valid = rst_n & ~bus.redirect_valid & (w_used < LP_DEPTH);
   assign w_req_fire  = w_req_valid & bus.im_req_ready;

   assign w_inflight_nxt = r_inflight + 2'(w_req_fire) - 2'(w_rsp_fire);

   assign bus.im_req_valid = w_req_valid;
   assign bus.im_req_addr  = r_fetch_pc;
   assign bus.id_valid     = w_id_valid;
   assign bus.id_pc        = w_bypass ? w_rsp_pc         : r_buf_pc[r_buf_rd];
   assign bus.id_inst      = w_bypass ? bus.im_rsp_data  : r_buf_inst[r_buf_rd];

   // fetch address and outstanding-request counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_inflight <= w_inflight_nxt;
         if (bus.redirect_valid) begin
            r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            // everything still outstanding after this cycle is stale
            r_drop_cnt <= w_inflight_nxt;
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_rsp_fire && (r_drop_cnt != 2'd0)) begin
               r_drop_cnt <= r_drop_cnt - 2'd1;
            end
         end
      end
   end

   // PC queue: pushed on request acceptance, popped on every counted response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            r_pcq[i] <= '0;
         end
         r_pcq_wr <= 1'b0;
         r_pcq_rd <= 1'b0;
      end else begin
         if (w_req_fire) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
            r_pcq_wr        <= ~r_pcq_wr;
         end
         if (w_rsp_fire) begin
            r_pcq_rd <= ~r_pcq_rd;
         end
      end
   end

   // fetch buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            r_buf_pc[i]   <= '0;
            r_buf_inst[i] <= '0;
         end
         r_buf_wr  <= 1'b0;
         r_buf_rd  <= 1'b0;
         r_buf_cnt <= '0;
      end else if (bus.redirect_valid) begin
         // flush wins over any decode handshake in the same cycle
         r_buf_wr  <= 1'b0;
         r_buf_rd  <= 1'b0;
         r_buf_cnt <= '0;
      end else begin
         if (w_push) begin
            r_buf_pc[r_buf_wr]   <= w_rsp_pc;
            r_buf_inst[r_buf_wr] <= bus.im_rsp_data;
            r_buf_wr             <= ~r_buf_wr;
         end
         if (w_pop) begin
            r_buf_rd <= ~r_buf_rd;
         end
         r_buf_cnt <= r_buf_cnt + 2'(w_push) - 2'(w_pop);
      end
   end

   a_buf_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && !w_pop && (r_buf_cnt == 2'd2)));

   a_inflight_bound : assert property (@(posedge clk) disable iff (!rst_n)
      !(w_req_fire && !w_rsp_fire && (r_inflight == 2'd2)));

   a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (bus.im_req_valid && !bus.im_req_ready) |=> $stable(bus.im_req_addr));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef FETCH_BYPASS_EN
   localparam logic [31:0] LP_BYP      = 32'd1;
   localparam logic [31:0] LP_STALL_PC = 32'd20;
`else
   localparam logic [31:0] LP_BYP      = 32'd0;
   localparam logic [31:0] LP_STALL_PC = 32'd16;
`endif

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a + 32'h1000_0013;
   endfunction

   // memory model: responds in order, lat cycles after acceptance
   int unsigned cyc      = 0;
   int unsigned lat      = 1;
   bit          rsp_auto = 1'b1;
   logic [31:0] q_addr [$];
   int unsigned q_due  [$];

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
         end else if (rsp_auto && bus.im_req_valid && bus.im_req_ready) begin
            q_addr.push_back(bus.im_req_addr);
            q_due.push_back(cyc + lat);
         end
         @(posedge clk);
         cyc++;
         #1;
         if (rsp_auto) begin
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
               bus.im_rsp_valid = 1'b1;
               bus.im_rsp_data  = inst_of(q_addr.pop_front());
               void'(q_due.pop_front());
            end else begin
               bus.im_rsp_valid = 1'b0;
            end
         end
      end
   end

   // decode-side log of every completed handshake
   logic [31:0] log_pc   [$];
   logic [31:0] log_inst [$];

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.id_valid && bus.id_ready) begin
            log_pc.push_back(bus.id_pc);
            log_inst.push_back(bus.id_inst);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_log(input string tag, input logic [31:0] base);
      for (int i = 0; i < log_pc.size(); i++) begin
         check({tag, "_pc"},   log_pc[i],   base + 32'(4 * i));
         check({tag, "_inst"}, log_inst[i], inst_of(base + 32'(4 * i)));
      end
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.im_req_ready   = 1'b1;
      bus.im_rsp_valid   = 1'b0;
      bus.im_rsp_data    = '0;
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      // reset state
      step();
      step();
      #1;
      check("rst_req_valid", 32'(bus.im_req_valid), 32'd0);
      check("rst_id_valid",  32'(bus.id_valid),     32'd0);
      check("rst_id_pc",     bus.id_pc,             32'd0);
      check("rst_id_inst",   bus.id_inst,           32'd0);
      check("rst_addr",      bus.im_req_addr,       32'd0);

      // streaming from reset release, one fetch per cycle
      step();
      rst_n = 1'b1;
      #1;
      check("c0_valid", 32'(bus.im_req_valid), 32'd1);
      check("c0_addr",  bus.im_req_addr,       32'd0);
      for (int k = 1; k <= 5; k++) begin
         step();
         #1;
         check("stream_valid", 32'(bus.im_req_valid), 32'd1);
         check("stream_addr",  bus.im_req_addr,       32'(4 * k));
         if (k == 1) begin
            check("c1_id_valid", 32'(bus.id_valid), LP_BYP);
         end
      end

      // decode stall for 5 cycles
      step();
      bus.id_ready = 1'b0;
      #1;
      step();
      step();
      #1;
      check("stall_req_valid", 32'(bus.im_req_valid), 32'd0);
      check("stall_id_valid",  32'(bus.id_valid),     32'd1);
      check("stall_id_pc",     bus.id_pc,             LP_STALL_PC);
      check("stall_id_inst",   bus.id_inst,           inst_of(LP_STALL_PC));
      step();
      step();
      #1;
      check("stall2_req_valid", 32'(bus.im_req_valid), 32'd0);
      check("stall2_id_pc",     bus.id_pc,             LP_STALL_PC);
      check("stall2_id_inst",   bus.id_inst,           inst_of(LP_STALL_PC));
      step();
      bus.id_ready = 1'b1;
      for (int k = 0; k < 6; k++) step();
      bus.im_req_ready = 1'b0;
      for (int k = 0; k < 5; k++) step();
      #1;
      check("drain_id_valid", 32'(bus.id_valid), 32'd0);
      check("stream_count_ok", 32'(log_pc.size() >= 10), 32'd1);
      check_log("stream", 32'd0);

      // redirect with two requests outstanding
      log_pc.delete();
      log_inst.delete();
      lat = 3;
      step();
      bus.im_req_ready = 1'b1;
      #1;
      check("a0_valid", 32'(bus.im_req_valid), 32'd1);
      step();
      #1;
      check("a1_valid", 32'(bus.im_req_valid), 32'd1);
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      #1;
      check("a2_valid", 32'(bus.im_req_valid), 32'd0);
      step();
      bus.redirect_valid = 1'b0;
      #1;
      check("a3_valid",    32'(bus.im_req_valid), 32'd1);
      check("a3_addr",     bus.im_req_addr,       32'h0000_0100);
      check("a3_id_valid", 32'(bus.id_valid),     32'd0);
      step();
      #1;
      check("a4_addr",     bus.im_req_addr,       32'h0000_0104);
      check("a4_id_valid", 32'(bus.id_valid),     32'd0);
      for (int k = 0; k < 4; k++) step();
      bus.im_req_ready = 1'b0;
      for (int k = 0; k < 7; k++) step();
      #1;
      check("redir_count_ok", 32'(log_pc.size() >= 2), 32'd1);
      check_log("redir", 32'h0000_0100);
      lat = 1;

      // redirect coinciding with a response and a decode handshake
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0300;
      step();
      bus.redirect_valid = 1'b0;
      bus.im_req_ready   = 1'b1;
      #1;
      check("b0_addr", bus.im_req_addr, 32'h0000_0300);
      step();
      bus.id_ready = 1'b0;
      step();
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      #1;
      check("b2_rsp_valid",  32'(bus.im_rsp_valid), 32'd1);
      check("b2_id_valid",   32'(bus.id_valid),     32'd1);
      check("b2_id_pc",      bus.id_pc,             32'h0000_0300);
      check("b2_req_valid",  32'(bus.im_req_valid), 32'd0);
      step();
      bus.redirect_valid = 1'b0;
      #1;
      check("b3_id_valid",  32'(bus.id_valid),     32'd0);
      check("b3_req_valid", 32'(bus.im_req_valid), 32'd1);
      check("b3_addr",      bus.im_req_addr,       32'h0000_0200);
      log_pc.delete();
      log_inst.delete();
      step();
      bus.im_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) step();
      #1;
      check("b_log_size", 32'(log_pc.size()), 32'd1);
      check_log("b_log", 32'h0000_0200);

      // address wrap at the top of the address space
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      step();
      bus.redirect_valid = 1'b0;
      bus.im_req_ready   = 1'b1;
      #1;
      check("wrap_addr_top", bus.im_req_addr, 32'hFFFF_FFFC);
      step();
      bus.im_req_ready = 1'b0;
      #1;
      check("wrap_addr_zero", bus.im_req_addr, 32'h0000_0000);
      for (int k = 0; k < 3; k++) step();

      // response-to-decode latency with data 0x13
      rsp_auto = 1'b0;
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0400;
      step();
      bus.redirect_valid = 1'b0;
      bus.im_req_ready   = 1'b1;
      #1;
      check("byp_req_addr", bus.im_req_addr, 32'h0000_0400);
      step();
      bus.im_req_ready = 1'b0;
      bus.im_rsp_valid = 1'b1;
      bus.im_rsp_data  = 32'h0000_0013;
      bus.id_ready     = 1'b0;
      #1;
      check("byp_same_id_valid", 32'(bus.id_valid), LP_BYP);
`ifdef FETCH_BYPASS_EN
      check("byp_same_id_inst", bus.id_inst, 32'h0000_0013);
      check("byp_same_id_pc",   bus.id_pc,   32'h0000_0400);
`endif
      step();
      bus.im_rsp_valid = 1'b0;
      #1;
      check("byp_next_id_valid", 32'(bus.id_valid), 32'd1);
      check("byp_next_id_inst",  bus.id_inst,       32'h0000_0013);
      check("byp_next_id_pc",    bus.id_pc,         32'h0000_0400);
      step();
      bus.id_ready = 1'b1;
      step();
      #1;
      check("byp_drained", 32'(bus.id_valid), 32'd0);

      // reset mid-operation abandons outstanding requests
      step();
      bus.im_req_ready = 1'b1;
      step();
      step();
      rst_n            = 1'b0;
      bus.im_req_ready = 1'b0;
      #1;
      check("mid_rst_req_valid", 32'(bus.im_req_valid), 32'd0);
      check("mid_rst_id_valid",  32'(bus.id_valid),     32'd0);
      check("mid_rst_addr",      bus.im_req_addr,       32'd0);
      step();
      rst_n            = 1'b1;
      bus.im_rsp_valid = 1'b1;
      bus.im_rsp_data  = 32'h0000_DEAD;
      #1;
      check("post_rst_req_valid", 32'(bus.im_req_valid), 32'd1);
      check("post_rst_addr",      bus.im_req_addr,       32'd0);
      check("stray_id_valid",     32'(bus.id_valid),     32'd0);
      step();
      bus.im_rsp_valid = 1'b0;
      #1;
      check("stray_id_valid2", 32'(bus.id_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
